// File: rtl/pulse_stretcher_pkg.sv
// Shared mode and state encodings for the multi-channel pulse stretcher.
package pulse_stretcher_pkg;

  localparam logic MODE_IGNORE = 1'b0;
  localparam logic MODE_RETRIG = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_e;

endpackage

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: rising-edge detect, IDLE/ACTIVE FSM, down-counter and
// saturating count of triggers dropped while already active.
module pulse_stretch_ch
  import pulse_stretcher_pkg::*;
#(
  parameter int N      = 32,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse,
  input  logic [N-1:0]      len,
  input  logic              sel,
  output logic              pulse_en,
  output logic              en_nxt,
  output logic [N-1:0]      count,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [N-1:0] ONE = N'(1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  ch_state_e state;
  logic      pulse_q;
  logic      trig_ok;

  // A zero length disables the channel, so such an edge is not a trigger at all.
  always_comb begin
    trig_ok = pulse & ~pulse_q & (len != '0);
    en_nxt  = 1'b0;
    if (!reset) begin
      if (state == ST_ACTIVE) en_nxt = (count != '0) | trig_ok;
      else                    en_nxt = trig_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pulse_q  <= 1'b1;
      pulse_en <= 1'b0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      pulse_q <= pulse;
      case (state)
        ST_IDLE: begin
          if (trig_ok) begin
            state    <= ST_ACTIVE;
            pulse_en <= 1'b1;
            count    <= len - ONE;
          end
        end
        ST_ACTIVE: begin
          // A trigger on the final cycle always reloads, giving gap-free back-to-back pulses.
          if (trig_ok && (count == '0 || sel == MODE_RETRIG)) begin
            count <= len - ONE;
          end else if (count != '0) begin
            count <= count - ONE;
            if (trig_ok) drop_cnt <= sat_inc(drop_cnt);
          end else begin
            state    <= ST_IDLE;
            pulse_en <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          pulse_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_stretcher_mc.sv
// Multi-channel pulse stretcher: NCH independent channels sharing one mode select,
// plus a registered busy flag aligned with the stretched outputs.
module pulse_stretcher_mc
  import pulse_stretcher_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int N      = 32,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        pulse,
  input  logic [NCH*N-1:0]      len,
  input  logic                  sel,
  output logic [NCH-1:0]        pulse_en,
  output logic [NCH*N-1:0]      count,
  output logic [NCH*DROP_W-1:0] drop_cnt,
  output logic                  busy
);

  logic [NCH-1:0] en_nxt;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_stretch_ch #(
      .N      (N),
      .DROP_W (DROP_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pulse    (pulse[i]),
      .len      (len[i*N +: N]),
      .sel      (sel),
      .pulse_en (pulse_en[i]),
      .en_nxt   (en_nxt[i]),
      .count    (count[i*N +: N]),
      .drop_cnt (drop_cnt[i*DROP_W +: DROP_W])
    );
  end

  // Built from next-state enables so busy changes on the same edge as pulse_en.
  always_ff @(posedge clk) begin
    if (reset) busy <= 1'b0;
    else       busy <= |en_nxt;
  end

endmodule
